keypad_digit_source: RTL and testbench

Scans a 4x4 active-low matrix keypad, synchronizes and debounces the row lines, and emits one hex key code with a single-cycle `enter` strobe per physical keypress. It is the producer side of the lock FSM's `digit`/`enter` input pair. It sits between the board keypad pins and the lock FSM, with no buffering: one press gives exactly one strobe.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_digit_source_if.sv | 24 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/keypad_digit_source.sv | 131 +++++++++++++
 tb/tb_keypad_digit_source.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad digit source: FSM states, idle row
// pattern and the {row, col} key-code packing.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_HELD,
    ST_RELEASE
  } state_e;

  localparam logic [3:0] ROWS_IDLE = 4'hF;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // True when exactly one active-low row is asserted.
  function automatic logic single_low(input logic [3:0] rs);
    int n_low;
    n_low = 0;
    for (int i = 0; i < 4; i++) begin
      if (!rs[i]) n_low++;
    end
    return (n_low == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rs);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rs[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_digit_source_if.sv
// Keypad pins plus the digit/enter pair handed to the lock FSM.
interface keypad_digit_source_if;
  logic [3:0] row_sense;
  logic [3:0] col_drive;
  logic [3:0] digit;
  logic       enter;
  logic       key_held;

  modport master (
    input  row_sense,
    output col_drive,
    output digit,
    output enter,
    output key_held
  );

  modport slave (
    output row_sense,
    input  col_drive,
    input  digit,
    input  enter,
    input  key_held
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, with a selectable
// reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_digit_source.sv
// 4x4 active-low keypad scanner: one debounced hex code and a single enter
// strobe per physical press, released only after a debounced all-idle period.
//
// state    | meaning
// SCAN     | rotate columns, sample rows on last dwell cycle
// DEBOUNCE | column frozen, count cycles matching latched single-low row
// EMIT     | one-cycle enter strobe, digit shows the new code
// HELD     | key down, wait for all rows idle
// RELEASE  | count idle cycles; any low row goes back to HELD
module keypad_digit_source
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_digit_source_if.master kp
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]        w_rs;
  state_e            r_state,    w_state_nxt;
  logic [1:0]        r_col,      w_col_nxt;
  logic [1:0]        r_row,      w_row_nxt;
  logic [SCAN_W-1:0] r_scan_cnt, w_scan_nxt;
  logic [DEB_W-1:0]  r_deb_cnt,  w_deb_nxt;
  logic [3:0]        r_digit,    w_digit_nxt;
  logic [3:0]        w_row_pat;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (ROWS_IDLE)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (kp.row_sense),
    .o_q   (w_rs)
  );

  // Single-low pattern expected from the latched row while debouncing.
  assign w_row_pat = ~(4'b0001 << r_row);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_SCAN;
      r_col      <= 2'd0;
      r_row      <= 2'd0;
      r_scan_cnt <= '0;
      r_deb_cnt  <= '0;
      r_digit    <= 4'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_scan_cnt <= w_scan_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_digit    <= w_digit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_scan_nxt  = r_scan_cnt;
    w_deb_nxt   = r_deb_cnt;
    w_digit_nxt = r_digit;
    case (r_state)
      ST_SCAN: begin
        if (r_scan_cnt == SCAN_LAST) begin
          w_scan_nxt = '0;
          if (single_low(w_rs)) begin
            w_row_nxt   = low_index(w_rs);
            w_deb_nxt   = '0;
            w_state_nxt = ST_DEBOUNCE;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end else begin
          w_scan_nxt = r_scan_cnt + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (w_rs == w_row_pat) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_state_nxt = ST_EMIT;
            w_digit_nxt = key_code(r_row, r_col);
          end else begin
            w_deb_nxt = r_deb_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = ST_SCAN;
          w_col_nxt   = r_col + 2'd1;
          w_scan_nxt  = '0;
        end
      end
      ST_EMIT: w_state_nxt = ST_HELD;
      ST_HELD: begin
        if (w_rs == ROWS_IDLE) begin
          w_deb_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (w_rs == ROWS_IDLE) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_state_nxt = ST_SCAN;
            w_col_nxt   = r_col + 2'd1;
            w_scan_nxt  = '0;
          end else begin
            w_deb_nxt = r_deb_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  assign kp.col_drive = ~(4'b0001 << r_col);
  assign kp.digit     = r_digit;
  assign kp.enter     = (r_state == ST_EMIT);
  assign kp.key_held  = (r_state == ST_HELD) || (r_state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_digit_source.sv
// Bench for keypad_digit_source: behavioural 4x4 matrix, table of key presses,
// hand-written corner sequences, and a digit scoreboard checked on each enter.
module tb_keypad_digit_source;

  localparam int SD        = 4;
  localparam int DEB       = 8;
  localparam int LAT_MAX   = 4 * SD + DEB + 3;
  localparam int REL_CYC   = DEB + 3;      // 2 sync + 1 idle detect in HELD + DEB idle cycles
  localparam int CHAT_CYC  = REL_CYC + 7;  // 6 lost RELEASE cycles + 1 HELD re-detect
  localparam int WAIT_MAX  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  row_force = 4'hF;
  logic [3:0]  m_rows;
  logic        prev_enter = 1'b0;
  logic [3:0]  sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    int         hold;
    int         idle;
    logic [3:0] exp_digit;
  } vec_t;

  vec_t vecs[8];

  keypad_digit_source_if kp();

  keypad_digit_source #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp.master)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    m_rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r * 4 + c] && !kp.col_drive[c]) m_rows[r] = 1'b0;
      end
    end
    kp.row_sense = m_rows & row_force;
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && kp.enter) begin
      chk(!prev_enter, "enter_not_consecutive", int'(prev_enter), 0);
      if (sb_q.size() == 0) begin
        chk(1'b0, "unexpected_enter", int'(kp.digit), -1);
      end else begin
        logic [3:0] exp_d;
        exp_d = sb_q.pop_front();
        chk(kp.digit == exp_d, "digit_on_enter", int'(kp.digit), int'(exp_d));
      end
    end
    prev_enter = kp.enter;
  end

  task automatic wait_enter(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      lat++;
      if (kp.enter) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Counts cycles from release until key_held drops; optional one-cycle row blip.
  task automatic measure_release(input int blip_at, output int n);
    n = WAIT_MAX;
    for (int i = 1; i <= WAIT_MAX; i++) begin
      @(negedge clk);
      if (blip_at != 0 && i == blip_at) row_force = 4'hE;
      if (blip_at != 0 && i == blip_at + 1) row_force = 4'hF;
      if (!kp.key_held) begin
        n = i;
        break;
      end
    end
    row_force = 4'hF;
  endtask

  task automatic press_key(input logic [1:0] row, input logic [1:0] col, input int hold,
                           input int idle, input logic [3:0] exp_d, input int blip_at,
                           input int exp_rel);
    int lat;
    int n_rel;
    bit ok;
    @(negedge clk);
    sb_q.push_back(exp_d);
    keys[int'(row) * 4 + int'(col)] = 1'b1;
    wait_enter(lat, ok);
    chk(ok && lat <= LAT_MAX, "press_latency", lat, LAT_MAX);
    @(negedge clk);
    chk(kp.key_held == 1'b1, "held_after_enter", int'(kp.key_held), 1);
    repeat (hold) @(negedge clk);
    chk(kp.key_held == 1'b1, "held_during_press", int'(kp.key_held), 1);
    keys = '0;
    measure_release(blip_at, n_rel);
    chk(n_rel == exp_rel, "release_cycles", n_rel, exp_rel);
    chk(kp.digit == exp_d, "digit_held", int'(kp.digit), int'(exp_d));
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    int         lat;
    int         n_rel;
    bit         ok;
    logic [3:0] seen_cols;

    vecs[0] = '{row: 2'd2, col: 2'd1, hold: 200, idle: 40, exp_digit: 4'h9};
    vecs[1] = '{row: 2'd0, col: 2'd1, hold: 30,  idle: 40, exp_digit: 4'h1};
    vecs[2] = '{row: 2'd0, col: 2'd2, hold: 30,  idle: 40, exp_digit: 4'h2};
    vecs[3] = '{row: 2'd0, col: 2'd3, hold: 30,  idle: 40, exp_digit: 4'h3};
    vecs[4] = '{row: 2'd1, col: 2'd0, hold: 30,  idle: 40, exp_digit: 4'h4};
    vecs[5] = '{row: 2'd0, col: 2'd0, hold: 20,  idle: 20, exp_digit: 4'h0};
    vecs[6] = '{row: 2'd3, col: 2'd3, hold: 20,  idle: 20, exp_digit: 4'hF};
    vecs[7] = '{row: 2'd3, col: 2'd0, hold: 20,  idle: 20, exp_digit: 4'hC};

    repeat (3) @(negedge clk);
    chk(kp.col_drive == 4'b1110, "reset_col_drive", int'(kp.col_drive), 14);
    chk(kp.digit == 4'h0, "reset_digit", int'(kp.digit), 0);
    chk(kp.enter == 1'b0, "reset_enter", int'(kp.enter), 0);
    chk(kp.key_held == 1'b0, "reset_key_held", int'(kp.key_held), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      press_key(vecs[v].row, vecs[v].col, vecs[v].hold, vecs[v].idle,
                vecs[v].exp_digit, 0, REL_CYC);
    end

    // Bouncy press on key 3: no strobe until the contact settles.
    for (int t = 0; t < 10; t++) begin
      keys[3] = ~keys[3];
      repeat (3) @(negedge clk);
    end
    keys[3] = 1'b1;
    sb_q.push_back(4'h3);
    wait_enter(lat, ok);
    chk(ok && lat <= LAT_MAX, "bounce_latency", lat, LAT_MAX);
    repeat (20) @(negedge clk);
    keys = '0;
    measure_release(0, n_rel);
    chk(n_rel == REL_CYC, "bounce_release_cycles", n_rel, REL_CYC);
    repeat (20) @(negedge clk);

    // Ghosting: two rows low in column 0 must be ignored while scan keeps going.
    keys[4] = 1'b1;
    keys[8] = 1'b1;
    seen_cols = 4'h0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      seen_cols = seen_cols | ~kp.col_drive;
      if (kp.key_held) break;
    end
    chk(kp.key_held == 1'b0, "ghost_key_held", int'(kp.key_held), 0);
    chk(seen_cols == 4'hF, "ghost_scan_rotates", int'(seen_cols), 15);
    keys = '0;
    repeat (20) @(negedge clk);

    // Reset while key 9 is held: immediate idle outputs, then one re-detect.
    @(negedge clk);
    sb_q.push_back(4'h9);
    keys[9] = 1'b1;
    wait_enter(lat, ok);
    chk(ok && lat <= LAT_MAX, "pre_reset_latency", lat, LAT_MAX);
    repeat (10) @(negedge clk);
    chk(kp.key_held == 1'b1, "held_before_reset", int'(kp.key_held), 1);
    reset = 1'b1;
    @(negedge clk);
    chk(kp.col_drive == 4'b1110, "rst_hold_col_drive", int'(kp.col_drive), 14);
    chk(kp.key_held == 1'b0, "rst_hold_key_held", int'(kp.key_held), 0);
    chk(kp.enter == 1'b0, "rst_hold_enter", int'(kp.enter), 0);
    sb_q.push_back(4'h9);
    reset = 1'b0;
    wait_enter(lat, ok);
    chk(ok && lat <= LAT_MAX + 2, "post_reset_latency", lat, LAT_MAX + 2);
    repeat (20) @(negedge clk);
    keys = '0;
    measure_release(0, n_rel);
    chk(n_rel == REL_CYC, "post_reset_release", n_rel, REL_CYC);
    repeat (20) @(negedge clk);

    // Release chatter: one-cycle row blip at RELEASE count 5 sends it back to HELD.
    press_key(2'd1, 2'd2, 20, 30, 4'h6, 6, CHAT_CYC);

    chk(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
